alu_control_md: RTL and testbench

Parametrised successor to the combinational ALU control decoder. Decodes aluop/funct3/funct7 into a 4-bit ALU command for all RV32I ALU, branch and immediate ops. Adds an RV32M mode: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU run on an internal iterative unit. Sits in the EX stage behind a valid/ready handshake so the pipeline stalls while a multiply/divide is in flight.

---
 rtl/alu_control_md_pkg.sv | 56 +++++
 rtl/alu_control_md_md_iter.sv | 104 ++++++++++
 rtl/alu_control_md.sv | 158 +++++++++++++++
 tb/tb_alu_control_md.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_control_md_pkg.sv
// Shared definitions for the ALU control decoder: command codes, aluop and
// funct encodings, M-extension funct3 codes and the control FSM states.
package alu_defs;

    localparam logic [3:0] CMD_AND  = 4'b0000;
    localparam logic [3:0] CMD_OR   = 4'b0001;
    localparam logic [3:0] CMD_ADD  = 4'b0010;
    localparam logic [3:0] CMD_XOR  = 4'b0011;
    localparam logic [3:0] CMD_SLL  = 4'b0100;
    localparam logic [3:0] CMD_SRL  = 4'b0101;
    localparam logic [3:0] CMD_SUB  = 4'b0110;
    localparam logic [3:0] CMD_SRA  = 4'b0111;
    localparam logic [3:0] CMD_SLT  = 4'b1000;
    localparam logic [3:0] CMD_SLTU = 4'b1001;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Command for funct3 when funct7 selects the base (non-alternate) operation.
    function automatic logic [3:0] base_cmd(input logic [2:0] f3);
        logic [3:0] c;
        case (f3)
            3'b000:  c = CMD_ADD;
            3'b001:  c = CMD_SLL;
            3'b010:  c = CMD_SLT;
            3'b011:  c = CMD_SLTU;
            3'b100:  c = CMD_XOR;
            3'b101:  c = CMD_SRL;
            3'b110:  c = CMD_OR;
            default: c = CMD_AND;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_control_md_md_iter.sv
// Iterative multiply/divide: radix-2 shift-add multiplier and restoring divider
// working on operand magnitudes, with the sign applied to the final result.
module md_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            sign_a,
    input  logic            sign_b,
    input  logic            is_div,
    input  logic            sel_hi,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    logic            running_reg;
    logic [CW-1:0]   cnt_reg;
    logic            div_reg, hi_reg, neg_reg;
    logic [XLEN-1:0] opnd_reg, acc_hi_reg, acc_lo_reg;
    logic [XLEN-1:0] acc_hi_next, acc_lo_next;

    logic            neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] div_raw;

    assign neg_a = sign_a & a[XLEN-1];
    assign neg_b = sign_b & b[XLEN-1];
    assign mag_a = neg_a ? -a : a;
    assign mag_b = neg_b ? -b : b;

    assign mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
    assign div_shift = {acc_hi_reg, acc_lo_reg[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_reg};

    always_comb begin
        acc_hi_next = acc_hi_reg;
        acc_lo_next = acc_lo_reg;
        if (div_reg) begin
            // A cleared sign bit means the trial subtraction fits: keep it.
            if (!div_diff[XLEN]) begin
                acc_hi_next = div_diff[XLEN-1:0];
                acc_lo_next = {acc_lo_reg[XLEN-2:0], 1'b1};
            end else begin
                acc_hi_next = div_shift[XLEN-1:0];
                acc_lo_next = {acc_lo_reg[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_hi_next = mul_sum[XLEN:1];
            acc_lo_next = {mul_sum[0], acc_lo_reg[XLEN-1:1]};
        end
    end

    assign done    = running_reg && (cnt_reg == CW'(XLEN));
    assign prod    = {acc_hi_reg, acc_lo_reg};
    assign prod_s  = neg_reg ? -prod : prod;
    assign div_raw = hi_reg ? acc_hi_reg : acc_lo_reg;

    always_comb begin
        if (div_reg) begin
            result = neg_reg ? -div_raw : div_raw;
        end else begin
            result = hi_reg ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running_reg <= 1'b0;
            cnt_reg     <= '0;
            div_reg     <= 1'b0;
            hi_reg      <= 1'b0;
            neg_reg     <= 1'b0;
            opnd_reg    <= '0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
        end else if (start) begin
            running_reg <= 1'b1;
            cnt_reg     <= '0;
            div_reg     <= is_div;
            hi_reg      <= sel_hi;
            // Remainder follows the dividend sign; everything else is a xor b.
            neg_reg     <= (is_div && sel_hi) ? neg_a : (neg_a ^ neg_b);
            opnd_reg    <= mag_b;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= mag_a;
        end else if (running_reg) begin
            if (done) begin
                running_reg <= 1'b0;
            end else begin
                cnt_reg    <= cnt_reg + CW'(1);
                acc_hi_reg <= acc_hi_next;
                acc_lo_reg <= acc_lo_next;
            end
        end
    end

endmodule

// File: rtl/alu_control_md.sv
// EX-stage ALU control: decodes aluop/funct3/funct7 into an ALU command and
// runs RV32M operations on the iterative unit behind a valid/ready handshake.
module alu_control_md
    import alu_defs::*;
#(
    parameter int XLEN  = 32,
    parameter bit MD_EN = 1'b1,
    parameter int CMD_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CMD_W-1:0] alucmd,
    output logic             md_sel,
    output logic [XLEN-1:0]  md_result,
    output logic             illegal
);

    logic [3:0] cmd;
    logic       ill, is_m;

    always_comb begin
        cmd  = CMD_ADD;
        ill  = 1'b0;
        is_m = 1'b0;
        case (aluop)
            ALUOP_MEM: cmd = CMD_ADD;
            ALUOP_BR: begin
                case (funct3)
                    3'b000, 3'b001: cmd = CMD_SUB;
                    3'b100, 3'b101: cmd = CMD_SLT;
                    3'b110, 3'b111: cmd = CMD_SLTU;
                    default:        ill = 1'b1;
                endcase
            end
            ALUOP_R: begin
                if (funct7 == F7_BASE) begin
                    cmd = base_cmd(funct3);
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)      cmd = CMD_SUB;
                    else if (funct3 == 3'b101) cmd = CMD_SRA;
                    else                       ill = 1'b1;
                end else if (funct7 == F7_MULDIV && MD_EN) begin
                    is_m = 1'b1;
                end else begin
                    ill = 1'b1;
                end
            end
            default: begin
                // I-type: funct7 is immediate data except for the shift forms.
                case (funct3)
                    3'b000: cmd = CMD_ADD;
                    3'b001: if (funct7 == F7_BASE) cmd = CMD_SLL; else ill = 1'b1;
                    3'b101: begin
                        if (funct7 == F7_BASE)     cmd = CMD_SRL;
                        else if (funct7 == F7_ALT) cmd = CMD_SRA;
                        else                       ill = 1'b1;
                    end
                    default: cmd = base_cmd(funct3);
                endcase
            end
        endcase
        if (ill) cmd = CMD_ADD;
    end

    logic            b_zero, ovf, special, go_busy;
    logic [XLEN-1:0] special_res;
    logic            sign_a, sign_b, sel_hi;

    assign b_zero  = (op_b == '0);
    assign ovf     = (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign special = is_m && funct3[2] && (b_zero || (!funct3[0] && ovf));
    assign go_busy = is_m && !special;

    always_comb begin
        if (b_zero) special_res = funct3[1] ? op_a : '1;
        else        special_res = funct3[1] ? '0 : op_a;
    end

    assign sign_a = !(funct3 inside {M_MULHU, M_DIVU, M_REMU});
    assign sign_b = sign_a && (funct3 != M_MULHSU);
    assign sel_hi = funct3[2] ? funct3[1] : (funct3 != M_MUL);

    state_e          state_reg, state_next;
    logic            accept, md_done;
    logic [XLEN-1:0] md_res;

    assign in_ready = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = go_busy ? ST_BUSY : ST_DONE;
            ST_BUSY: if (md_done) state_next = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    if (accept) state_next = go_busy ? ST_BUSY : ST_DONE;
                    else        state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    md_iter #(.XLEN(XLEN)) u_md_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && go_busy),
        .sign_a (sign_a),
        .sign_b (sign_b),
        .is_div (funct3[2]),
        .sel_hi (sel_hi),
        .a      (op_a),
        .b      (op_b),
        .done   (md_done),
        .result (md_res)
    );

    logic [CMD_W-1:0] alucmd_reg;
    logic             md_sel_reg, illegal_reg;
    logic [XLEN-1:0]  md_result_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            alucmd_reg    <= CMD_W'(CMD_ADD);
            md_sel_reg    <= 1'b0;
            md_result_reg <= '0;
            illegal_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                alucmd_reg    <= CMD_W'(cmd);
                md_sel_reg    <= is_m;
                illegal_reg   <= ill;
                md_result_reg <= special ? special_res : '0;
            end else if ((state_reg == ST_BUSY) && md_done) begin
                md_result_reg <= md_res;
            end
        end
    end

    assign out_valid = (state_reg == ST_DONE);
    assign alucmd    = alucmd_reg;
    assign md_sel    = md_sel_reg;
    assign md_result = md_result_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_control_md.sv
// Randomized self-checking bench for alu_control_md against a behavioural
// reference computed with plain 64-bit arithmetic; includes an MD_EN=0 instance.
module tb_alu_control_md;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    logic [1:0]  aluop;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op_a, op_b;
    logic        in_ready, out_valid, md_sel, illegal;
    logic [3:0]  alucmd;
    logic [31:0] md_result;
    logic        nm_in_ready, nm_out_valid, nm_md_sel, nm_illegal;
    logic [3:0]  nm_alucmd;
    logic [31:0] nm_md_result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_control_md #(.XLEN(32), .MD_EN(1'b1), .CMD_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .alucmd(alucmd),
        .md_sel(md_sel), .md_result(md_result), .illegal(illegal)
    );

    alu_control_md #(.XLEN(32), .MD_EN(1'b0), .CMD_W(4)) dut_nm (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nm_in_ready),
        .aluop(aluop), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
        .out_valid(nm_out_valid), .out_ready(out_ready), .alucmd(nm_alucmd),
        .md_sel(nm_md_sel), .md_result(nm_md_result), .illegal(nm_illegal)
    );

    typedef struct packed {
        logic [3:0]  cmd;
        logic        sel;
        logic        ill;
        logic [31:0] res;
        logic        lng;
    } exp_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: instruction semantics straight from the ISA tables.
    function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] a,
                                   input logic [31:0] b, input bit md_en);
        exp_t e;
        logic [3:0] tbl [8];
        longint sa, sb, ub, p;
        longint unsigned ua, pu;
        tbl = '{4'd2, 4'd4, 4'd8, 4'd9, 4'd3, 4'd5, 4'd1, 4'd0};
        e = '{cmd: 4'd2, sel: 1'b0, ill: 1'b0, res: 32'd0, lng: 1'b0};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        ua = {32'd0, a};
        if (op == 2'd1) begin
            if (f3 <= 3'd1)      e.cmd = 4'd6;
            else if (f3 <= 3'd3) e.ill = 1'b1;
            else if (f3 <= 3'd5) e.cmd = 4'd8;
            else                 e.cmd = 4'd9;
        end else if (op == 2'd2) begin
            if (f7 == 7'h00) e.cmd = tbl[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) e.cmd = 4'd6;
            else if (f7 == 7'h20 && f3 == 3'd5) e.cmd = 4'd7;
            else if (f7 == 7'h01 && md_en) begin
                e.sel = 1'b1;
                e.lng = 1'b1;
                case (f3)
                    3'd0: begin p = sa * sb; e.res = p[31:0]; end
                    3'd1: begin p = sa * sb; e.res = p[63:32]; end
                    3'd2: begin p = sa * ub; e.res = p[63:32]; end
                    3'd3: begin pu = ua * ua; pu = ua * {32'd0, b}; e.res = pu[63:32]; end
                    3'd4, 3'd6: begin
                        if (b == 32'd0) begin
                            e.res = (f3 == 3'd4) ? 32'hFFFF_FFFF : a;
                            e.lng = 1'b0;
                        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                            e.res = (f3 == 3'd4) ? a : 32'd0;
                            e.lng = 1'b0;
                        end else begin
                            p = (f3 == 3'd4) ? sa / sb : sa % sb;
                            e.res = p[31:0];
                        end
                    end
                    default: begin
                        if (b == 32'd0) begin
                            e.res = (f3 == 3'd5) ? 32'hFFFF_FFFF : a;
                            e.lng = 1'b0;
                        end else begin
                            e.res = (f3 == 3'd5) ? a / b : a % b;
                        end
                    end
                endcase
            end else e.ill = 1'b1;
        end else if (op == 2'd3) begin
            if (f3 == 3'd1)      begin if (f7 == 7'h00) e.cmd = 4'd4; else e.ill = 1'b1; end
            else if (f3 == 3'd5) begin
                if (f7 == 7'h00)      e.cmd = 4'd5;
                else if (f7 == 7'h20) e.cmd = 4'd7;
                else                  e.ill = 1'b1;
            end else e.cmd = tbl[f3];
        end
        if (e.ill) e.cmd = 4'd2;
        return e;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // One transaction: present, wait for accept, wait for result, check, optional stall.
    task automatic do_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input int stall,
                         input bit hold, input bit ready_now);
        exp_t e, en;
        int n, lat;
        logic [31:0] held;
        e  = model(op, f3, f7, a, b, 1'b1);
        en = model(op, f3, f7, a, b, 1'b0);
        aluop = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        if (ready_now) check("ready_same_cycle", in_ready, 1);
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        if (n >= 100) check("accept_timeout", n, 0);
        tick();
        in_valid = 1'b0;
        check("nm_valid", nm_out_valid, 1);
        check("nm_cmd", nm_alucmd, en.cmd);
        check("nm_ill", nm_illegal, en.ill);
        check("nm_sel", nm_md_sel, en.sel);
        check("nm_res", nm_md_result, en.res);
        lat = 0;
        while (!out_valid && lat < 100) begin
            check("busy_ready", in_ready, 0);
            tick();
            lat++;
        end
        check("latency", lat, e.lng ? 33 : 0);
        check("cmd", alucmd, e.cmd);
        check("sel", md_sel, e.sel);
        check("ill", illegal, e.ill);
        check("res", md_result, e.res);
        $display("op aluop=%b f3=%b f7=%b a=%h b=%h -> cmd=%b sel=%b ill=%b res=%h lat=%0d",
                 op, f3, f7, a, b, alucmd, md_sel, illegal, md_result, lat);
        held = md_result;
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_res", md_result, held);
            check("stall_ready", in_ready, 0);
        end
        if (!hold) out_ready = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int stale;
        logic [6:0] f7r;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        aluop = 2'd0; funct3 = 3'd0; funct7 = 7'd0; op_a = 32'd0; op_b = 32'd0;
        repeat (3) tick();
        check("rst_valid", out_valid, 0);
        check("rst_cmd", alucmd, 4'b0010);
        check("rst_sel", md_sel, 0);
        check("rst_res", md_result, 0);
        check("rst_ill", illegal, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        // Directed cases
        do_op(2'b10, 3'b000, 7'h20, 32'd0, 32'd0, 0, 0, 0);
        do_op(2'b10, 3'b101, 7'h20, 32'd0, 32'd0, 0, 0, 0);
        do_op(2'b10, 3'b111, 7'h00, 32'd0, 32'd0, 0, 0, 0);
        do_op(2'b01, 3'b110, 7'h00, 32'd0, 32'd0, 0, 0, 0);
        do_op(2'b11, 3'b000, 7'h20, 32'd0, 32'd0, 0, 0, 0);
        do_op(2'b11, 3'b001, 7'h20, 32'd0, 32'd0, 0, 0, 0);
        do_op(2'b10, 3'b000, 7'h01, 32'd7, 32'hFFFF_FFFD, 0, 0, 0);
        do_op(2'b10, 3'b011, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        do_op(2'b10, 3'b100, 7'h01, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        do_op(2'b10, 3'b110, 7'h01, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        do_op(2'b10, 3'b101, 7'h01, 32'h1234_5678, 32'd0, 0, 0, 0);
        do_op(2'b10, 3'b100, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        do_op(2'b10, 3'b110, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);

        // Backpressure on a DIV result, then same-cycle accept on release
        do_op(2'b10, 3'b100, 7'h01, 32'd1000, 32'hFFFF_FFF9, 5, 1, 0);
        do_op(2'b10, 3'b010, 7'h00, 32'd0, 32'd0, 0, 0, 1);

        // Back-to-back non-M ops at one per cycle
        for (int i = 0; i < 8; i++) begin
            aluop = 2'($urandom_range(0, 3));
            funct3 = 3'($urandom);
            funct7 = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
            in_valid = 1'b1;
            e = model(aluop, funct3, funct7, 32'd0, 32'd0, 1'b1);
            tick();
            check("b2b_valid", out_valid, 1);
            check("b2b_cmd", alucmd, e.cmd);
            check("b2b_ill", illegal, e.ill);
            check("b2b_sel", md_sel, 0);
            $display("b2b aluop=%b f3=%b f7=%b -> cmd=%b ill=%b", aluop, funct3, funct7, alucmd, illegal);
        end
        in_valid = 1'b0;
        tick();

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: f7r = 7'h00;
                1: f7r = 7'h20;
                2: f7r = 7'h01;
                default: f7r = 7'($urandom);
            endcase
            do_op(2'($urandom_range(0, 3)), 3'($urandom), f7r, rnd_val(), rnd_val(),
                  $urandom_range(0, 2), 0, 0);
        end

        // Reset during a multiply in flight
        aluop = 2'b10; funct3 = 3'b000; funct7 = 7'h01; op_a = $urandom; op_b = $urandom;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        check("midop_busy", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_cmd", alucmd, 4'b0010);
        check("midrst_sel", md_sel, 0);
        check("midrst_res", md_result, 0);
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) stale++;
        end
        check("no_stale_result", stale, 0);
        $display("reset mid-op: valid=%b ready=%b stale=%0d", out_valid, in_ready, stale);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
